// File: rtl/cska_pipe.sv
// cska_pipe: pipelined carry-skip adder/subtractor, one carry-skip block per
// pipeline stage (L = N/BLOCK_SIZE stages, latency L cycles).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_ready = !(out_valid && !out_ready)
//   A, B, Cin, sub    operands, carry-in (add only), 0 = add / 1 = subtract
//   out_valid/out_ready output handshake
//   Sum, Cout, Ovf    result, carry out of MSB (no-borrow on subtract),
//                     signed overflow
module cska_pipe #(
  parameter int unsigned N          = 16,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int unsigned L = N / BLOCK_SIZE;

  // Per-stage registers. B is carried raw and inverted per stage using the
  // registered sub flag, so the flag travels with its operands.
  logic [L-1:0][N-1:0] a_q, a_d;
  logic [L-1:0][N-1:0] b_q, b_d;
  logic [L-1:0][N-1:0] s_q, s_d;
  logic [L-1:0]        c_q, c_d;
  logic [L-1:0]        sub_q, sub_d;
  logic [L-1:0]        v_q, v_d;

  logic stall;
  logic a_msb, b_msb;

  // One carry-skip block: ripple through bits [k*BLOCK_SIZE +: BLOCK_SIZE];
  // if every bit propagates, the block carry-out is the block carry-in.
  function automatic void skip_block(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b_raw,
    input  logic         inv,
    input  logic         cin,
    input  logic [N-1:0] s_in,
    input  int unsigned  k,
    output logic [N-1:0] s_out,
    output logic         c_out
  );
    logic [N-1:0] b;
    logic         rc;
    logic         p;
    b     = b_raw ^ {N{inv}};
    s_out = s_in;
    rc    = cin;
    p     = 1'b1;
    for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
      s_out[k*BLOCK_SIZE+j] = a[k*BLOCK_SIZE+j] ^ b[k*BLOCK_SIZE+j] ^ rc;
      rc = (a[k*BLOCK_SIZE+j] & b[k*BLOCK_SIZE+j]) |
           (rc & (a[k*BLOCK_SIZE+j] ^ b[k*BLOCK_SIZE+j]));
      p  = p & (a[k*BLOCK_SIZE+j] ^ b[k*BLOCK_SIZE+j]);
    end
    c_out = p ? cin : rc;
  endfunction

  assign stall    = v_q[L-1] && !out_ready;
  assign in_ready = !stall;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    c_d = c_q;
    sub_d = sub_q;
    v_d = v_q;

    // Stage 0 takes operands straight from the ports; subtract forces carry-in 1.
    a_d[0]   = A;
    b_d[0]   = B;
    sub_d[0] = sub;
    v_d[0]   = in_valid && in_ready;
    skip_block(A, B, sub, sub | Cin, '0, 0, s_d[0], c_d[0]);

    for (int unsigned k = 1; k < L; k++) begin
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      sub_d[k] = sub_q[k-1];
      v_d[k]   = v_q[k-1];
      skip_block(a_q[k-1], b_q[k-1], sub_q[k-1], c_q[k-1], s_q[k-1], k,
                 s_d[k], c_d[k]);
    end
  end

  // The whole pipeline advances or holds as one, so bubbles are never squeezed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      sub_q <= '0;
      v_q   <= '0;
    end else if (!stall) begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      sub_q <= sub_d;
      v_q   <= v_d;
    end
  end

  // Overflow uses the MSBs of the effective operands (B inverted on subtract).
  assign a_msb     = a_q[L-1][N-1];
  assign b_msb     = b_q[L-1][N-1] ^ sub_q[L-1];
  assign out_valid = v_q[L-1];
  assign Sum       = s_q[L-1];
  assign Cout      = c_q[L-1];
  assign Ovf       = (a_msb == b_msb) && (s_q[L-1][N-1] != a_msb);

endmodule

// File: tb/tb_cska_pipe.sv
// Testbench for cska_pipe (N=16, BLOCK_SIZE=4): directed vectors push their
// hand-computed results into a scoreboard queue; a monitor pops and compares
// whenever a result is handed over.
module tb_cska_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] Sum;
  logic        Cout;
  logic        Ovf;

  int          tests = 0;
  int          fails = 0;
  int          popped = 0;
  logic [17:0] q[$];
  logic [17:0] mon_e;

  always #5 clk = ~clk;

  cska_pipe #(.N(16), .BLOCK_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference for the random stream: {Cout, Ovf, Sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sb);
    logic [15:0] be;
    logic [16:0] t;
    logic        ov;
    be = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, be} + {16'd0, (sb ? 1'b1 : ci)};
    ov = (a[15] == be[15]) && (t[15] != a[15]);
    return {t[16], ov, t[15:0]};
  endfunction

  // Monitor: a result is consumed at the next rising edge when valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h expected none", {Cout, Ovf, Sum});
        end else begin
          mon_e = q.pop_front();
          check("result", 32'({Cout, Ovf, Sum}), 32'(mon_e));
          popped++;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic sb, input logic [17:0] e);
    int unsigned n;
    bit done;
    n = 0;
    done = 0;
    A = a; B = b; Cin = ci; sub = sb; in_valid = 1'b1;
    while (!done) begin
      #3;
      if (in_ready) begin
        q.push_back(e);
        done = 1;
      end
      @(negedge clk);
      if (!done) begin
        n++;
        if (n > 100) begin
          tests++;
          fails++;
          $display("FAIL issue_timeout: got in_ready=0 expected 1");
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // After a single accepted input, out_valid must rise exactly on the 4th edge.
  task automatic lat_check(input string tag);
    for (int d = 0; d < 4; d++) begin
      #3;
      check($sformatf("%s_lat%0d", tag, d), 32'(out_valid), 32'(d == 3));
      @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_drain", tag), 32'(q.size()), 32'd0);
  endtask

  task automatic reset_state(input string tag);
    check($sformatf("%s_out_valid", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s_sum", tag), 32'(Sum), 32'd0);
    check($sformatf("%s_cout", tag), 32'(Cout), 32'd0);
    check($sformatf("%s_ovf", tag), 32'(Ovf), 32'd0);
    check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd1);
  endtask

  logic [15:0] bp_a [6] = '{16'h1000, 16'h2000, 16'h0F0F, 16'h4000, 16'h0001, 16'h0003};
  logic [15:0] bp_b [6] = '{16'h0234, 16'h0321, 16'hF0F0, 16'h4000, 16'h0001, 16'h0004};
  logic        bp_c [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [17:0] bp_e [6] = '{{2'b00, 16'h1234}, {2'b00, 16'h2322}, {2'b10, 16'h0000},
                            {2'b01, 16'h8000}, {2'b00, 16'h0002}, {2'b00, 16'h0007}};

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc;
    int cycles;
    int p0;
    logic [17:0] held;
    logic [15:0] ra, rb;
    logic        rci, rsb;

    // Reset state while rst_n is low.
    #2;
    reset_state("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Latency and basic add.
    issue(16'h00FF, 16'h0001, 1'b1, 1'b0, {2'b00, 16'h0101});
    lat_check("add0");

    // Directed vectors, back to back.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b10, 16'h0000});
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {2'b10, 16'hFFFF});
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, {2'b00, 16'hFFFE});
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, {2'b01, 16'h8000});
    issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, {2'b10, 16'h0000});
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, {2'b11, 16'h7FFF});
    drain("directed");

    // Backpressure: six cycles of in_valid with out_ready low.
    out_ready = 1'b0;
    acc = 0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      A = bp_a[i]; B = bp_b[i]; Cin = bp_c[i]; sub = 1'b0; in_valid = 1'b1;
      #3;
      if (in_ready) begin
        q.push_back(bp_e[i]);
        acc++;
      end
      if (i >= 4) begin
        check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
        check($sformatf("bp_out_valid%0d", i), 32'(out_valid), 32'd1);
      end
      if (i == 4) held = {Cout, Ovf, Sum};
      if (i == 5) check("bp_stable5", 32'({Cout, Ovf, Sum}), 32'(held));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd4);
    for (int i = 0; i < 2; i++) begin
      #3;
      check($sformatf("bp_hold%0d", i), 32'({out_valid, Cout, Ovf, Sum}), 32'({1'b1, held}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check($sformatf("bp_release%0d", i), 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    #3;
    check("bp_after", 32'(out_valid), 32'd0);
    check("bp_queue", 32'(q.size()), 32'd0);
    @(negedge clk);

    // Random stream with random in_valid / out_ready.
    p0 = popped;
    acc = 0;
    cycles = 0;
    ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom); rsb = 1'($urandom);
    while (acc < 100 && cycles < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      A = ra; B = rb; Cin = rci; sub = rsb;
      #3;
      if (in_valid && in_ready) begin
        q.push_back(model(ra, rb, rci, rsb));
        acc++;
        ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom); rsb = 1'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_accepted", 32'(acc), 32'd100);
    drain("rand");
    @(negedge clk);
    check("rand_popped", 32'(popped - p0), 32'd100);

    // Reset with three results in flight, one of them already at the output.
    out_ready = 1'b0;
    issue(16'h1111, 16'h1111, 1'b0, 1'b0, {2'b00, 16'h2222});
    issue(16'h2222, 16'h2222, 1'b0, 1'b0, {2'b00, 16'h4444});
    issue(16'h3333, 16'h3333, 1'b0, 1'b0, {2'b00, 16'h6666});
    @(negedge clk);
    #1;
    check("flush_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    reset_state("rst1");
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 16'h1234, 1'b1, 1'b1, {2'b10, 16'h0000});
    lat_check("post_rst");
    for (int i = 0; i < 6; i++) begin
      #3;
      check($sformatf("post_rst_idle%0d", i), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    check("final_queue", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
